// File: rtl/text_line_fill_if.sv
// text_line_fill_if: bus between the text line filler and its surroundings.
// master (filler): inputs hcount, vcount, tr_rd_data, font_data;
//                  outputs tr_rd_addr, font_addr, pixbuf_wr (active-low), pixbuf_wr_addr, pixbuf_wr_data.
// slave (timing_gen, text RAM, font ROM, pixbuf): the opposite directions.
interface text_line_fill_if;
    logic [15:0] hcount;
    logic [15:0] vcount;
    logic [11:0] tr_rd_addr;
    logic [15:0] tr_rd_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        pixbuf_wr;
    logic [9:0]  pixbuf_wr_addr;
    logic [15:0] pixbuf_wr_data;
    modport master (
        input  hcount, vcount, tr_rd_data, font_data,
        output tr_rd_addr, font_addr, pixbuf_wr, pixbuf_wr_addr, pixbuf_wr_data
    );
    modport slave (
        output hcount, vcount, tr_rd_data, font_data,
        input  tr_rd_addr, font_addr, pixbuf_wr, pixbuf_wr_addr, pixbuf_wr_data
    );
endinterface

// File: rtl/text_line_fill.sv
// text_line_fill: renders the next scanline of 100x37 text into the pixel buffer just behind the beam.
// Ports: clk (pixel clock), nrst (sync active-low reset), bus (text_line_fill_if.master):
//   hcount/vcount in, tr_rd_addr/tr_rd_data text RAM, font_addr/font_data font ROM, pixbuf_wr* write port.
module text_line_fill (
    input logic              clk,
    input logic              nrst,
    text_line_fill_if.master bus
);
    localparam int H_VISIBLE  = 800;
    localparam int V_VISIBLE  = 600;
    localparam int V_TOTAL    = 628;
    localparam int COLS       = 100;
    localparam int TEXT_ROWS  = 37;
    localparam int FILL_START = 4;
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };
    typedef enum logic [1:0] {IDLE, FILL, BLANK} state_t;
    state_t      state_q, state_d;
    logic [9:0]  cyc_q, cyc_d;
    logic [11:0] base_q, base_d;
    logic [3:0]  glyph_q, glyph_d;
    logic [3:0]  fg_q, fg_d, bg_q, bg_d;
    logic [7:0]  sh_q, sh_d;
    logic [3:0]  pf_q, pf_d, pb_q, pb_d;
    logic [11:0] tr_q, tr_d;
    logic [11:0] fa_q, fa_d;
    logic        wr_q, wr_d;
    logic [9:0]  wa_q, wa_d;
    logic [15:0] wd_q, wd_d;
    logic [15:0] tgt;
    logic [9:0]  pix;
    logic [11:0] colour;
    assign tgt    = (bus.vcount == 16'(V_TOTAL - 1)) ? 16'd0 : bus.vcount + 16'd1;
    // cyc_q counts cycles since the trigger; pixel p is registered when cyc_q == p+3
    assign pix    = cyc_q - 10'd3;
    assign colour = PALETTE[sh_q[3'd7 - pix[2:0]] ? pf_q : pb_q];
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + 10'd1;
        base_d  = base_q;
        glyph_d = glyph_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        sh_d    = sh_q;
        pf_d    = pf_q;
        pb_d    = pb_q;
        tr_d    = tr_q;
        fa_d    = fa_q;
        wr_d    = 1'b1;
        wa_d    = wa_q;
        wd_d    = wd_q;
        if (state_q == IDLE) begin
            cyc_d = '0;
            if (bus.hcount == 16'(FILL_START) && tgt < 16'(V_VISIBLE)) begin
                state_d = (tgt < 16'(TEXT_ROWS * 16)) ? FILL : BLANK;
                base_d  = {6'd0, tgt[9:4]} * 12'd100;
                glyph_d = tgt[3:0];
            end
        end else begin
            // three-stage fetch per 8-cycle cell: text address, font address + attrs, glyph into shifter;
            // the shifter reload coincides with the last pixel of the previous cell
            if (state_q == FILL && cyc_q < 10'(COLS * 8)) begin
                if (cyc_q[2:0] == 3'd0)
                    tr_d = base_q + 12'(cyc_q[9:3]);
                if (cyc_q[2:0] == 3'd1) begin
                    fa_d = {bus.tr_rd_data[7:0], glyph_q};
                    fg_d = bus.tr_rd_data[11:8];
                    bg_d = bus.tr_rd_data[15:12];
                end
                if (cyc_q[2:0] == 3'd2) begin
                    sh_d = bus.font_data;
                    pf_d = fg_q;
                    pb_d = bg_q;
                end
            end
            if (cyc_q >= 10'd3) begin
                wr_d = 1'b0;
                wa_d = pix;
                wd_d = (state_q == FILL) ? {4'd0, colour} : 16'd0;
            end
            if (cyc_q == 10'(H_VISIBLE + 2))
                state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            base_q  <= '0;
            glyph_q <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            sh_q    <= '0;
            pf_q    <= '0;
            pb_q    <= '0;
            tr_q    <= '0;
            fa_q    <= '0;
            wr_q    <= 1'b1;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            base_q  <= base_d;
            glyph_q <= glyph_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            sh_q    <= sh_d;
            pf_q    <= pf_d;
            pb_q    <= pb_d;
            tr_q    <= tr_d;
            fa_q    <= fa_d;
            wr_q    <= wr_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end
    assign bus.tr_rd_addr     = tr_q;
    assign bus.font_addr      = fa_q;
    assign bus.pixbuf_wr      = wr_q;
    assign bus.pixbuf_wr_addr = wa_q;
    assign bus.pixbuf_wr_data = wd_q;
endmodule

// File: tb/tb_text_line_fill.sv
// tb_text_line_fill: randomized scoreboard bench for text_line_fill.
module tb_text_line_fill;
    localparam logic [11:0] PAL [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };
    typedef struct { int addr; int data; int hc; } wr_t;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [15:0] tram [4096];
    logic [7:0]  fnt  [4096];
    wr_t q[$];
    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int mkind = 0;
    int mbase = 0;
    int mg = 0;
    int mtr = 0;
    int mfa = 0;
    text_line_fill_if bus();
    text_line_fill dut (.clk(clk), .nrst(nrst), .bus(bus));
    assign bus.tr_rd_data = tram[bus.tr_rd_addr];
    assign bus.font_data  = fnt[bus.font_addr];
    always #5 clk = ~clk;
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (hcount %0d vcount %0d)", name, act, exp, bus.hcount, bus.vcount);
        end
    endtask
    // reference: cell word -> glyph row -> palette colour for pixel p of a text line
    function automatic int ref_pixel(int base, int g, int p);
        logic [15:0] c = tram[base + p / 8];
        logic [7:0]  f = fnt[{c[7:0], 4'(g)}];
        return int'(f[7 - p % 8] ? PAL[c[11:8]] : PAL[c[15:12]]);
    endfunction
    task automatic randomize_mem();
        for (int i = 0; i < 4096; i++) begin
            tram[i] = 16'($urandom);
            fnt[i]  = 8'($urandom);
        end
    endtask
    task automatic tick();
        int t;
        int h;
        @(posedge clk);
        if (!nrst) begin
            q.delete();
            mkind = 0;
            mtr = 0;
            mfa = 0;
        end else if (bus.hcount == 16'd4) begin
            t = (bus.vcount == 16'd627) ? 0 : int'(bus.vcount) + 1;
            mkind = (t >= 600) ? 0 : (t >= 592) ? 2 : 1;
            mbase = (t / 16) * 100;
            mg = t % 16;
            if (mkind != 0)
                for (int p = 0; p < 800; p++)
                    q.push_back('{p, (mkind == 1) ? ref_pixel(mbase, mg, p) : 0, 9 + p});
            if (mkind == 1) begin
                mtr = mbase + 99;
                mfa = int'({tram[mbase + 99][7:0], 4'(mg)});
            end
        end
        #1;
        bus.hcount = (bus.hcount == 16'd1055) ? 16'd0 : bus.hcount + 16'd1;
        h = int'(bus.hcount);
        if (mkind == 1 && h >= 6 && h < 806 && (h - 6) % 8 == 0)
            chk("tr_rd_addr", int'(bus.tr_rd_addr), mbase + (h - 6) / 8);
        if (mkind == 1 && h >= 7 && h < 807 && (h - 7) % 8 == 0)
            chk("font_addr", int'(bus.font_addr), int'({tram[mbase + (h - 7) / 8][7:0], 4'(mg)}));
        if (mkind == 2 && h == 808) begin
            chk("blank_tr_hold", int'(bus.tr_rd_addr), mtr);
            chk("blank_font_hold", int'(bus.font_addr), mfa);
        end
    endtask
    task automatic run_line(int v, int abort_at);
        int w0 = wr_seen;
        int t = (v == 627) ? 0 : v + 1;
        bus.vcount = 16'(v);
        for (int i = 0; i < 1056; i++) begin
            tick();
            nrst = (int'(bus.hcount) == abort_at) ? 1'b0 : 1'b1;
        end
        chk("line_writes", wr_seen - w0, (t >= 600) ? 0 : (abort_at >= 0) ? abort_at - 8 : 800);
        chk("queue_left", q.size(), 0);
    endtask
    always @(negedge clk) begin
        wr_t e;
        if (bus.pixbuf_wr == 1'b0) begin
            wr_seen++;
            if (q.size() == 0) begin
                chk("unexpected_write", int'(bus.pixbuf_wr_addr), -1);
            end else begin
                e = q.pop_front();
                chk("wr_addr", int'(bus.pixbuf_wr_addr), e.addr);
                chk("wr_data", int'(bus.pixbuf_wr_data), e.data);
                chk("wr_hcount", int'(bus.hcount), e.hc);
                chk("wr_margin", int'(int'(bus.hcount) - 1 >= int'(bus.pixbuf_wr_addr) + 6), 1);
            end
        end
    end
    initial begin
        randomize_mem();
        tram[0] = 16'h1E41;
        fnt[12'h41A] = 8'h81;
        nrst = 1'b0;
        bus.vcount = 16'd9;
        bus.hcount = 16'd1053;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_wr", int'(bus.pixbuf_wr), 1);
        chk("rst_wr_addr", int'(bus.pixbuf_wr_addr), 0);
        chk("rst_wr_data", int'(bus.pixbuf_wr_data), 0);
        chk("rst_tr_addr", int'(bus.tr_rd_addr), 0);
        chk("rst_font_addr", int'(bus.font_addr), 0);
        chk("rst_no_writes", wr_seen, 0);
        nrst = 1'b1;
        run_line(9, -1);
        run_line(627, -1);
        run_line(590, -1);
        chk("last_row_tr", int'(bus.tr_rd_addr), 3699);
        run_line(591, -1);
        run_line(600, -1);
        run_line(626, -1);
        run_line(100, 300);
        chk("abort_wr_idle", int'(bus.pixbuf_wr), 1);
        run_line(101, -1);
        for (int n = 0; n < 8; n++) begin
            randomize_mem();
            run_line(int'($urandom_range(0, 627)), -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
